// File: rtl/bpsk_phase_gen.sv
// Phase-accumulator address generator for a 128-entry sine LUT with BPSK / 2DPSK
// half-cycle phase offsets applied per accepted data bit.
module bpsk_phase_gen #(
  parameter int ACC_W   = 16,
  parameter int BIT_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ACC_W-1:0] freq_word,
  input  logic             dpsk_en,
  input  logic             bit_data,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [6:0]       address,
  output logic             busy,
  output logic             bit_strobe,
  output logic             underrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next, acc_sum;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             offset_reg, offset_next;
  logic             ref_reg, ref_next;
  logic [6:0]       addr_reg, addr_next;
  logic             strobe_reg, strobe_next;
  logic             underrun_reg, underrun_next;
  logic             last_cnt, accept, new_offset, new_ref;

  assign last_cnt  = (cnt_reg == CNT_W'(BIT_LEN - 1));
  assign bit_ready = reset_n & ((state_reg == IDLE) | last_cnt);
  assign accept    = bit_valid & bit_ready;

  // Differential mode chains the offset through ref; absolute mode leaves ref alone.
  assign new_offset = dpsk_en ? (ref_reg ^ bit_data) : bit_data;
  assign new_ref    = dpsk_en ? new_offset : ref_reg;
  assign acc_sum    = acc_reg + freq_word;

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    offset_next   = offset_reg;
    ref_next      = ref_reg;
    addr_next     = addr_reg;
    strobe_next   = 1'b0;
    underrun_next = 1'b0;
    case (state_reg)
      IDLE: begin
        acc_next  = '0;
        cnt_next  = '0;
        addr_next = 7'd0;
        if (accept) begin
          state_next  = RUN;
          offset_next = new_offset;
          ref_next    = new_ref;
          addr_next   = {new_offset, 6'b0};
          strobe_next = 1'b1;
        end
      end
      RUN: begin
        if (!last_cnt) begin
          acc_next  = acc_sum;
          cnt_next  = cnt_reg + CNT_W'(1);
          addr_next = acc_sum[ACC_W-1 -: 7] + {offset_reg, 6'b0};
        end else if (accept) begin
          // Phase-continuous bit boundary: only the offset changes.
          acc_next    = acc_sum;
          cnt_next    = '0;
          offset_next = new_offset;
          ref_next    = new_ref;
          addr_next   = acc_sum[ACC_W-1 -: 7] + {new_offset, 6'b0};
          strobe_next = 1'b1;
        end else begin
          state_next    = IDLE;
          acc_next      = '0;
          cnt_next      = '0;
          offset_next   = 1'b0;
          ref_next      = 1'b0;
          addr_next     = 7'd0;
          underrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      offset_reg   <= 1'b0;
      ref_reg      <= 1'b0;
      addr_reg     <= 7'd0;
      strobe_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      offset_reg   <= offset_next;
      ref_reg      <= ref_next;
      addr_reg     <= addr_next;
      strobe_reg   <= strobe_next;
      underrun_reg <= underrun_next;
    end
  end

  assign address    = addr_reg;
  assign busy       = (state_reg == RUN);
  assign bit_strobe = strobe_reg;
  assign underrun   = underrun_reg;

endmodule
